ram_arbiter: RTL

- Shares the single-port program/video RAM (clk_ram domain) between three requesters: UART program loader, screen scanner and the 6502 core.
- Halts the CPU through its RDY input whenever it does not own the RAM.
- Sequences the CPU reset after a program download. The reset counts only cycles in which the CPU actually owns the RAM, so the 6502 always sees a full reset even while the screen steals cycles.

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: program loader > screen scanner > 6502 core.
// Also sequences the CPU reset, counting only cycles in which the CPU owns the RAM.
module ram_arbiter #(
    parameter int unsigned RESET_CYCLES  = 8,
    parameter int unsigned VID_MAX_BURST = 4
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic        prog_ask,
    input  logic [15:0] prog_addr,
    input  logic [7:0]  prog_wdata,
    input  logic        prog_we,
    input  logic        prog_end,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_rvalid,
    output logic [7:0]  vid_rdata,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic        cpu_reset,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    localparam int unsigned CNT_W   = $clog2(RESET_CYCLES + 1);
    localparam int unsigned BURST_W = $clog2(VID_MAX_BURST + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PROG = 2'd1,
        RST  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               ack_d1;
    logic               grant_vid;
    logic               cpu_reset_d;
    logic               cpu_rdy_d;
    logic               vid_ack_d;
    logic [15:0]        ram_addr_d;
    logic [7:0]         ram_wdata_d;
    logic               ram_we_d;

    // Register stage: every output and all arbitration state.
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state_q    <= RUN;
            rst_cnt_q  <= CNT_W'(RESET_CYCLES);
            burst_q    <= '0;
            cpu_reset  <= 1'b1;
            cpu_rdy    <= 1'b0;
            vid_ack    <= 1'b0;
            ack_d1     <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= 8'h00;
            ram_addr   <= 16'h0000;
            ram_wdata  <= 8'h00;
            ram_we     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            burst_q    <= burst_d;
            cpu_reset  <= cpu_reset_d;
            cpu_rdy    <= cpu_rdy_d;
            vid_ack    <= vid_ack_d;
            ack_d1     <= vid_ack;
            vid_rvalid <= ack_d1;
            if (ack_d1) begin
                vid_rdata <= ram_rdata;
            end
            ram_addr   <= ram_addr_d;
            ram_wdata  <= ram_wdata_d;
            ram_we     <= ram_we_d;
        end
    end

    // Next-state and grant decision; the power-up sequence is RUN with cpu_reset still high.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        burst_d     = burst_q;
        cpu_reset_d = cpu_reset;
        cpu_rdy_d   = 1'b0;
        vid_ack_d   = 1'b0;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ram_we_d    = 1'b0;
        grant_vid   = vid_req && (burst_q < BURST_W'(VID_MAX_BURST));

        case (state_q)
            PROG: begin
                ram_addr_d  = prog_addr;
                ram_wdata_d = prog_wdata;
                ram_we_d    = prog_we;
                burst_d     = '0;
                if (prog_end) begin
                    state_d     = RST;
                    rst_cnt_d   = CNT_W'(RESET_CYCLES);
                    cpu_reset_d = 1'b1;
                end else if (!prog_ask) begin
                    state_d = RUN;
                end
            end
            default: begin
                if (prog_ask) begin
                    state_d     = PROG;
                    ram_addr_d  = prog_addr;
                    ram_wdata_d = prog_wdata;
                    ram_we_d    = prog_we;
                    burst_d     = '0;
                end else begin
                    if (grant_vid) begin
                        vid_ack_d  = 1'b1;
                        ram_addr_d = vid_addr;
                        burst_d    = burst_q + BURST_W'(1);
                    end else begin
                        cpu_rdy_d   = 1'b1;
                        ram_addr_d  = cpu_addr;
                        ram_wdata_d = cpu_wdata;
                        ram_we_d    = cpu_we && !cpu_reset;
                        burst_d     = '0;
                    end
                    // Reset length counts CPU-owned cycles only; release one cycle after reaching 0.
                    if (cpu_reset) begin
                        if (rst_cnt_q == '0) begin
                            cpu_reset_d = 1'b0;
                            state_d     = RUN;
                        end else if (!grant_vid) begin
                            rst_cnt_d = rst_cnt_q - CNT_W'(1);
                        end
                    end
                end
            end
        endcase
    end

endmodule
